// File: rtl/tpu_pkg.sv
// Shared types and constants for the mmu job arbiter slice.
package tpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int MAT_W       = 32;
  localparam int ELEM_W      = 8;
  localparam int TIMEOUT_DEF = 16;
  localparam int WD_W        = 8;

  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mmu_job_arbiter_if.sv
// Requester, response and mmu-side signals of the job arbiter.
interface mmu_job_arbiter_if
  import tpu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = id_width(NUM_REQ)
);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*MAT_W-1:0] req_a;
  logic [NUM_REQ*MAT_W-1:0] req_b;

  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic [MAT_W-1:0]         rsp_c;
  logic                     rsp_err;

  logic                     mmu_rst;
  logic [MAT_W-1:0]         mmu_a;
  logic [MAT_W-1:0]         mmu_b;
  logic [MAT_W-1:0]         mmu_c;
  logic                     mmu_done;

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready, mmu_c, mmu_done,
    output req_ready, rsp_valid, rsp_id, rsp_c, rsp_err, mmu_rst, mmu_a, mmu_b
  );

  modport master (
    output req_valid, req_a, req_b, rsp_ready, mmu_c, mmu_done,
    input  req_ready, rsp_valid, rsp_id, rsp_c, rsp_err, mmu_rst, mmu_a, mmu_b
  );

endinterface

// File: rtl/mmu_job_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester at or above i_ptr, wrapping.
module rr_arbiter
  import tpu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [ID_W-1:0]    o_idx,
  output logic               o_any
);

  always_comb begin
    int v_idx;
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    v_idx = 0;
    // Scan farthest-first so the closest valid slot to the pointer wins last.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      v_idx = int'(i_ptr) + k;
      if (v_idx >= NUM_REQ) v_idx = v_idx - NUM_REQ;
      if (i_req[v_idx]) begin
        o_gnt        = '0;
        o_gnt[v_idx] = 1'b1;
        o_idx        = ID_W'(v_idx);
        o_any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mmu_job_arbiter.sv
// Shares one mmu between NUM_REQ requesters: round-robin grant, run, watchdog, tagged response.
module mmu_job_arbiter
  import tpu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  mmu_job_arbiter_if.slave bus
);

  // IDLE: mmu in reset, grant | RUN: mmu released, watchdog counts | RESP: hold result until taken
  state_t             r_state;
  logic [ID_W-1:0]    r_ptr;
  logic [ID_W-1:0]    r_gid;
  logic [WD_W-1:0]    r_wd;
  logic               r_mmu_rst;
  logic [MAT_W-1:0]   r_mmu_a;
  logic [MAT_W-1:0]   r_mmu_b;
  logic               r_rsp_valid;
  logic [ID_W-1:0]    r_rsp_id;
  logic [MAT_W-1:0]   r_rsp_c;
  logic               r_rsp_err;

  logic [NUM_REQ-1:0] w_gnt;
  logic [ID_W-1:0]    w_idx;
  logic               w_any;
  logic [ID_W-1:0]    w_ptr_next;
  logic [WD_W-1:0]    w_wd_next;
  logic               w_timeout;
  logic [MAT_W-1:0]   w_a_sel;
  logic [MAT_W-1:0]   w_b_sel;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
    .i_req (bus.req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign w_a_sel    = bus.req_a[int'(w_idx)*MAT_W +: MAT_W];
  assign w_b_sel    = bus.req_b[int'(w_idx)*MAT_W +: MAT_W];
  assign w_ptr_next = (w_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_idx + ID_W'(1);
  assign w_wd_next  = r_wd + WD_W'(1);
  assign w_timeout  = (w_wd_next == WD_W'(TIMEOUT));

  // Gating with rst_n keeps the accept strobe quiet while reset is held.
  assign bus.req_ready = (r_state == ST_IDLE && rst_n) ? w_gnt : '0;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_c     = r_rsp_c;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.mmu_rst   = r_mmu_rst;
  assign bus.mmu_a     = r_mmu_a;
  assign bus.mmu_b     = r_mmu_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_gid       <= '0;
      r_wd        <= '0;
      r_mmu_rst   <= 1'b1;
      r_mmu_a     <= '0;
      r_mmu_b     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_c     <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_mmu_a   <= w_a_sel;
            r_mmu_b   <= w_b_sel;
            r_gid     <= w_idx;
            r_ptr     <= w_ptr_next;
            r_wd      <= '0;
            r_mmu_rst <= 1'b0;
            r_state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_wd <= w_wd_next;
          // A done left over from mmu reset can still be high in the first RUN cycle.
          if (bus.mmu_done && r_wd != '0) begin
            r_rsp_c     <= bus.mmu_c;
            r_rsp_err   <= 1'b0;
            r_rsp_id    <= r_gid;
            r_rsp_valid <= 1'b1;
            r_mmu_rst   <= 1'b1;
            r_state     <= ST_RESP;
          end else if (w_timeout) begin
            r_rsp_c     <= '0;
            r_rsp_err   <= 1'b1;
            r_rsp_id    <= r_gid;
            r_rsp_valid <= 1'b1;
            r_mmu_rst   <= 1'b1;
            r_state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_mmu_rst   <= 1'b1;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
